// File: rtl/integ_decim.sv
// Cascaded integrator bank with power-of-two decimation (the integrator half of a CIC).
// Define INTEG_TRUNC_EN to narrow data_out to Win bits (top bits of the last integrator).
module integ_decim #(
  parameter int Win  = 16,
  parameter int N    = 3,
  parameter int LOGR = 3,
  localparam int Wout = Win + N * LOGR,
`ifdef INTEG_TRUNC_EN
  localparam int DW = Win
`else
  localparam int DW = Wout
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 val_in,
  input  logic signed [Win-1:0] data_in,
  output logic                 val_out,
  output logic signed [DW-1:0] data_out
);

  logic signed [Wout-1:0] r_integ [N];
  logic        [LOGR-1:0] r_cnt;

  logic signed [Wout-1:0] w_sext;
  logic signed [Wout-1:0] w_next [N];
  logic signed [DW-1:0]   w_out_sel;
  logic                   w_last;

  // Every stage adds the pre-edge value of the stage before it, so the
  // cascade is pipelined one sample per stage.
  always_comb begin
    w_sext = {{(N * LOGR){data_in[Win-1]}}, data_in};
    for (int unsigned k = 0; k < N; k++) begin
      w_next[k] = r_integ[k];
    end
    w_next[0] = r_integ[0] + w_sext;
    for (int unsigned k = 1; k < N; k++) begin
      w_next[k] = r_integ[k] + r_integ[k-1];
    end
  end

`ifdef INTEG_TRUNC_EN
  assign w_out_sel = w_next[N-1][Wout-1:N*LOGR];
`else
  assign w_out_sel = w_next[N-1];
`endif

  assign w_last = (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        r_integ[k] <= '0;
      end
      r_cnt    <= '0;
      data_out <= '0;
      val_out  <= 1'b0;
    end else begin
      val_out <= 1'b0;
      if (val_in) begin
        for (int unsigned k = 0; k < N; k++) begin
          r_integ[k] <= w_next[k];
        end
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          data_out <= w_out_sel;
          val_out  <= 1'b1;
        end
      end
    end
  end

endmodule
